// File: rtl/dwt_pkg.sv
// Shared types and constants for the DWT frame sequencer.
package dwt_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned PHASES   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRIME,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

endpackage

// File: rtl/dwt_sample_fifo.sv
// Synchronous sample FIFO; a pop on empty returns zero and leaves state unchanged.
module dwt_sample_fifo
  import dwt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [SAMPLE_W-1:0]           push_data,
  input  logic                          pop,
  output logic [SAMPLE_W-1:0]           pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sample storage (contents need no reset)
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dwt_frame_sequencer.sv
// Frame controller: buffers input samples, clears and feeds the DWT datapath
// phase-aligned, zero-flushes it, and captures tagged L/H results.
module dwt_frame_sequencer
  import dwt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned START_LEVEL  = 4,
  parameter int unsigned GW           = 8,
  parameter int unsigned OUT_LAT      = 6,
  parameter int unsigned FLUSH_GROUPS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [GW-1:0]       cfg_frame_groups,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                dwt_reset,
  output logic [SAMPLE_W-1:0] dwt_in_data,
  input  logic [SAMPLE_W-1:0] dwt_L,
  input  logic [SAMPLE_W-1:0] dwt_H,
  output logic [SAMPLE_W-1:0] m_l,
  output logic [SAMPLE_W-1:0] m_h,
  output logic                m_valid,
  output logic                m_last,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun_err
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FLW  = $clog2(PHASES * FLUSH_GROUPS);
  localparam int unsigned TAGS = OUT_LAT - 1;
  localparam logic [CW-1:0]  START_LVL  = CW'(START_LEVEL);
  localparam logic [FLW-1:0] FLUSH_LAST = FLW'(PHASES * FLUSH_GROUPS - 1);

  state_t              state, state_nxt;
  logic [1:0]          phase;
  logic [1:0]          sub;
  logic [GW-1:0]       grp;
  logic [GW-1:0]       groups_q;
  logic [FLW-1:0]      flush_cnt;
  logic [TAGS-1:0]     tag_v;
  logic [TAGS-1:0]     tag_l;
  logic                tag_load;
  logic                last_grp;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_data;
  logic [CW-1:0]       fifo_count;

  dwt_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (s_valid),
    .push_data(s_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign s_ready  = !fifo_full;
  assign busy     = (state != IDLE);
  assign last_grp = (grp == groups_q - 1'b1);

  // Next-state, datapath feed and tag-load decode
  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    dwt_in_data = '0;
    tag_load    = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:  if (start && cfg_frame_groups != '0) state_nxt = CLEAR;
      CLEAR: state_nxt = PRIME;
      // Leave on phase 3 so the first RUN cycle lands on datapath phase 0
      PRIME: if (phase == 2'd3 && fifo_count >= START_LVL) state_nxt = RUN;
      RUN: begin
        fifo_pop    = 1'b1;
        dwt_in_data = fifo_data;
        tag_load    = (sub == 2'd0);
        if (sub == 2'd3 && last_grp) state_nxt = FLUSH;
      end
      FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      DRAIN: begin
        if (tag_v == '0 && !m_valid) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, counters, frame length latch and underrun flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dwt_reset    <= 1'b1;
      phase        <= '0;
      sub          <= '0;
      grp          <= '0;
      groups_q     <= '0;
      flush_cnt    <= '0;
      underrun_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwt_reset <= (state_nxt == CLEAR);
      phase     <= (state == CLEAR) ? 2'd0 : phase + 2'd1;
      if (state == IDLE && state_nxt == CLEAR) begin
        groups_q     <= cfg_frame_groups;
        underrun_err <= 1'b0;
      end else if (state == RUN && fifo_empty) begin
        underrun_err <= 1'b1;
      end
      if (state == CLEAR) begin
        sub <= '0;
        grp <= '0;
      end else if (state == RUN) begin
        sub <= sub + 2'd1;
        if (sub == 2'd3) grp <= grp + 1'b1;
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Tag pipeline; the m_valid register forms its final stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v   <= '0;
      tag_l   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_l     <= '0;
      m_h     <= '0;
    end else begin
      tag_v   <= (tag_v << 1) | TAGS'(tag_load);
      tag_l   <= (tag_l << 1) | TAGS'(tag_load && last_grp);
      m_valid <= tag_v[TAGS-1];
      m_last  <= tag_v[TAGS-1] && tag_l[TAGS-1];
      if (tag_v[TAGS-1]) begin
        m_l <= dwt_L;
        m_h <= dwt_H;
      end
    end
  end

endmodule

// File: tb/tb_dwt_frame_sequencer.sv
// Self-checking bench for dwt_frame_sequencer with a stand-in datapath.
module tb_dwt_frame_sequencer;

  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned START_LEVEL  = 4;
  localparam int unsigned GW           = 8;
  localparam int unsigned OUT_LAT      = 6;
  localparam int unsigned FLUSH_GROUPS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [GW-1:0] cfg_frame_groups = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          dwt_reset;
  logic [7:0]    dwt_in_data;
  logic [7:0]    dwt_L;
  logic [7:0]    dwt_H;
  logic [7:0]    m_l;
  logic [7:0]    m_h;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          underrun_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] src_q [$];
  logic [7:0] frame_data [$];
  logic       rdy_prev = 1'b0;
  logic [7:0] hist [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  dwt_frame_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .START_LEVEL (START_LEVEL),
    .GW          (GW),
    .OUT_LAT     (OUT_LAT),
    .FLUSH_GROUPS(FLUSH_GROUPS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_frame_groups(cfg_frame_groups),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .dwt_reset       (dwt_reset),
    .dwt_in_data     (dwt_in_data),
    .dwt_L           (dwt_L),
    .dwt_H           (dwt_H),
    .m_l             (m_l),
    .m_h             (m_h),
    .m_valid         (m_valid),
    .m_last          (m_last),
    .busy            (busy),
    .frame_done      (frame_done),
    .underrun_err    (underrun_err)
  );

  // Stand-in datapath: L/H are the sum/difference of the first two samples
  // of a group, emerging OUT_LAT-1 cycles after the group's first sample.
  always @(posedge clk) begin
    if (dwt_reset) begin
      for (int i = 0; i < 8; i++) hist[i] <= 8'h00;
    end else begin
      hist[0] <= dwt_in_data;
      for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end
  end
  assign dwt_L = hist[OUT_LAT-2] + hist[OUT_LAT-3];
  assign dwt_H = hist[OUT_LAT-2] - hist[OUT_LAT-3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the valid/ready source
  task automatic step();
    @(negedge clk);
    if (s_valid && rdy_prev) void'(src_q.pop_front());
    s_valid  = (src_q.size() != 0);
    s_data   = (src_q.size() != 0) ? src_q[0] : 8'h00;
    rdy_prev = s_ready;
  endtask

  task automatic load_random(input int n);
    logic [7:0] v;
    frame_data.delete();
    for (int k = 0; k < n; k++) begin
      v = 8'($urandom);
      frame_data.push_back(v);
      src_q.push_back(v);
    end
  endtask

  // Start a frame of g groups and check it against the frame rules.
  // Index 0 is the CLEAR cycle; RUN begins at index 5 (phase-aligned).
  task automatic run_frame(input int g, input bit mid_start, input bit exp_under);
    logic [7:0] e [$];
    logic [7:0] exp_in, exp_l, exp_h;
    int last_i, mv_cnt, done_cnt, done_at, rst_cnt, rst_at, gi;
    last_i = 4*g + 13;
    mv_cnt = 0; done_cnt = 0; done_at = -1; rst_cnt = 0; rst_at = -1;
    exp_l = 8'h00; exp_h = 8'h00;
    for (int k = 0; k < 4*g; k++) e.push_back(k < frame_data.size() ? frame_data[k] : 8'h00);
    cfg_frame_groups = GW'(g);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_frame_groups = GW'($urandom);
    for (int i = 0; i <= last_i + 3; i++) begin
      if (i == 0) check("underrun_cleared", underrun_err, 0);
      if (dwt_reset) begin
        rst_cnt++;
        if (rst_at < 0) rst_at = i;
      end
      if (i <= last_i) begin
        exp_in = (i >= 5 && i < 5 + 4*g) ? e[i-5] : 8'h00;
        check("dwt_in_data", dwt_in_data, exp_in);
      end
      if (m_valid) begin
        gi = mv_cnt;
        check("m_valid_time", i, 11 + 4*gi);
        if (gi < g) begin
          exp_l = e[4*gi] + e[4*gi+1];
          exp_h = e[4*gi] - e[4*gi+1];
          check("m_l", m_l, exp_l);
          check("m_h", m_h, exp_h);
          check("m_last", m_last, (gi == g-1));
        end
        mv_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        done_at = i;
      end
      if (mid_start && i == 8) begin
        cfg_frame_groups = GW'(1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("dwt_reset_pulses", rst_cnt, 1);
    check("dwt_reset_at", rst_at, 0);
    check("m_valid_count", mv_cnt, g);
    check("frame_done_count", done_cnt, 1);
    check("frame_done_at", done_at, last_i);
    check("m_l_hold", m_l, exp_l);
    check("m_h_hold", m_h, exp_h);
    check("busy_end", busy, 0);
    check("underrun_end", underrun_err, exp_under);
  endtask

  initial begin
    int dn;
    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_dwt_reset", dwt_reset, 1);
    check("rst_dwt_in", dwt_in_data, 0);
    check("rst_m_l", m_l, 0);
    check("rst_m_h", m_h, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun_err, 0);
    reset = 1'b1;

    // Preload 4 samples in IDLE
    for (int k = 0; k < 4; k++) src_q.push_back(8'(k));
    repeat (6) step();
    check("preload_s_ready", s_ready, 1);
    check("preload_count", 32'(dut.u_fifo.count), 4);
    check("preload_busy", busy, 0);
    check("idle_dwt_reset", dwt_reset, 0);

    // Nominal 3-group frame with ramp data 0..11
    frame_data.delete();
    for (int k = 0; k < 12; k++) frame_data.push_back(8'(k));
    for (int k = 4; k < 12; k++) src_q.push_back(8'(k));
    repeat (2) step();
    run_frame(3, 1'b0, 1'b0);

    // Zero-length start is ignored
    cfg_frame_groups = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("cfg0_dwt_reset", dwt_reset, 0);
    check("cfg0_busy", busy, 0);
    repeat (3) step();
    check("cfg0_busy_later", busy, 0);

    // Underrun: 2 groups, only 5 samples supplied
    load_random(5);
    repeat (7) step();
    run_frame(2, 1'b0, 1'b1);

    // Start pulsed during RUN has no effect
    load_random(8);
    repeat (10) step();
    run_frame(2, 1'b1, 1'b0);

    // Backpressure: 10 samples offered into an 8-deep FIFO
    load_random(10);
    repeat (12) step();
    check("bp_s_ready", s_ready, 0);
    check("bp_pending", src_q.size(), 2);
    check("bp_count", 32'(dut.u_fifo.count), 8);
    run_frame(3, 1'b0, 1'b1);

    // Mid-frame reset of a 4-group frame
    load_random(16);
    repeat (10) step();
    cfg_frame_groups = GW'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    src_q.delete();
    s_valid  = 1'b0;
    rdy_prev = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dwt_reset", dwt_reset, 1);
    check("mid_rst_dwt_in", dwt_in_data, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_l", m_l, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_count", 32'(dut.u_fifo.count), 0);
    repeat (2) step();
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_done) dn++;
      step();
    end
    check("mid_rst_no_done", dn, 0);

    // A following frame completes normally
    load_random(8);
    repeat (10) step();
    run_frame(2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
